// File: rtl/swap_initiator_pkg.sv
// Shared FSM encoding, default widths and read-mux select decode for swap_initiator.
package swap_initiator_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_WR_A = 3'd3,
        S_WR_B = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam int ADDR_W_DEF = 7;
    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 16;

    localparam logic [1:0] SEL_ZERO = 2'd0;
    localparam logic [1:0] SEL_A    = 2'd1;
    localparam logic [1:0] SEL_B    = 2'd2;

    // Read address only leaves zero during the two read states.
    function automatic logic [1:0] rd_sel(input state_t s);
        case (s)
            S_RD_A:  return SEL_A;
            S_RD_B:  return SEL_B;
            default: return SEL_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/swap_initiator_mux_4x1_nbits.sv
// 4:1 N-bit combinational selector.
// Latency: combinational. Backpressure: none.
module swap_initiator_mux_4x1_nbits #(
    parameter int N = 8
) (
    input  logic [1:0]   sel,
    input  logic [N-1:0] in0,
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    input  logic [N-1:0] in3,
    output logic [N-1:0] out
);

    always_comb begin
        out = in0;
        case (sel)
            2'd0:    out = in0;
            2'd1:    out = in1;
            2'd2:    out = in2;
            default: out = in3;
        endcase
    end

endmodule

// File: rtl/swap_initiator.sv
// Swaps two register-file words via read-read-write-write on an async-read/sync-write port.
// Latency: done 5 cycles after handshake (1 when addresses match). Backpressure: cmd_ready low while busy.
module swap_initiator
    import swap_initiator_pkg::*;
#(
    parameter int ADDR_width = ADDR_W_DEF,
    parameter int DATA_width = DATA_W_DEF,
    parameter int CNT_width  = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_width-1:0] cmd_addr_a,
    input  logic [ADDR_width-1:0] cmd_addr_b,
    output logic                  done,
    output logic                  busy,
    output logic [CNT_width-1:0]  swap_count,
    output logic [ADDR_width-1:0] mem_address_r,
    input  logic [DATA_width-1:0] mem_data_r,
    output logic                  mem_we,
    output logic [ADDR_width-1:0] mem_address_w,
    output logic [DATA_width-1:0] mem_data_w
);

    state_t                  state_q, state_d;
    logic [ADDR_width-1:0]   a_q, a_d;
    logic [ADDR_width-1:0]   b_q, b_d;
    logic [DATA_width-1:0]   tmp_a_q, tmp_a_d;
    logic [DATA_width-1:0]   tmp_b_q, tmp_b_d;
    logic [CNT_width-1:0]    swap_count_q, swap_count_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            tmp_a_q      <= '0;
            tmp_b_q      <= '0;
            swap_count_q <= '0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            tmp_a_q      <= tmp_a_d;
            tmp_b_q      <= tmp_b_d;
            swap_count_q <= swap_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        tmp_a_d      = tmp_a_q;
        tmp_b_d      = tmp_b_q;
        swap_count_d = swap_count_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    a_d     = cmd_addr_a;
                    b_d     = cmd_addr_b;
                    // A self-swap is a no-op on memory but still counts.
                    state_d = (cmd_addr_a == cmd_addr_b) ? S_DONE : S_RD_A;
                end
            end
            S_RD_A: begin
                tmp_a_d = mem_data_r;
                state_d = S_RD_B;
            end
            S_RD_B: begin
                tmp_b_d = mem_data_r;
                state_d = S_WR_A;
            end
            S_WR_A:  state_d = S_WR_B;
            S_WR_B:  state_d = S_DONE;
            S_DONE: begin
                swap_count_d = swap_count_q + CNT_width'(1);
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready     = (state_q == S_IDLE) && !reset;
        busy          = (state_q != S_IDLE);
        done          = (state_q == S_DONE);
        mem_we        = 1'b0;
        mem_address_w = '0;
        mem_data_w    = '0;
        case (state_q)
            S_WR_A: begin
                mem_we        = 1'b1;
                mem_address_w = a_q;
                mem_data_w    = tmp_b_q;
            end
            S_WR_B: begin
                mem_we        = 1'b1;
                mem_address_w = b_q;
                mem_data_w    = tmp_a_q;
            end
            default: ;
        endcase
    end

    assign swap_count = swap_count_q;

    swap_initiator_mux_4x1_nbits #(
        .N (ADDR_width)
    ) u_rd_mux (
        .sel (rd_sel(state_q)),
        .in0 ('0),
        .in1 (a_q),
        .in2 (b_q),
        .in3 ('0),
        .out (mem_address_r)
    );

endmodule

// File: tb/tb_swap_initiator.sv
// Directed table-driven bench for swap_initiator with a behavioural async-read/sync-write register file.
module tb_swap_initiator;

    localparam int AW = 7;
    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr_a, cmd_addr_b;
    logic          done, busy;
    logic [CW-1:0] swap_count;
    logic [AW-1:0] mem_address_r, mem_address_w;
    logic [DW-1:0] mem_data_r, mem_data_w;
    logic          mem_we;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_dat;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    swap_initiator #(
        .ADDR_width (AW),
        .DATA_width (DW),
        .CNT_width  (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr_a    (cmd_addr_a),
        .cmd_addr_b    (cmd_addr_b),
        .done          (done),
        .busy          (busy),
        .swap_count    (swap_count),
        .mem_address_r (mem_address_r),
        .mem_data_r    (mem_data_r),
        .mem_we        (mem_we),
        .mem_address_w (mem_address_w),
        .mem_data_w    (mem_data_w)
    );

    assign mem_data_r = mem[mem_address_r];

    always @(posedge clk) begin
        if (mem_we)      mem[mem_address_w] <= mem_data_w;
        else if (pre_we) mem[pre_addr]      <= pre_dat;
    end

    typedef struct {
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic [DW-1:0] va;
        logic [DW-1:0] vb;
        int            exp_lat;
        logic [DW-1:0] exp_fa;
        logic [DW-1:0] exp_fb;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [25:0] obs();
        return {mem_address_r, mem_we, mem_address_w, mem_data_w, done, busy, cmd_ready};
    endfunction

    function automatic logic [25:0] expv(input logic [AW-1:0] r, input logic we,
                                         input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                         input logic d, input logic b, input logic rdy);
        return {r, we, wa, wd, d, b, rdy};
    endfunction

    task automatic preload(input logic [AW-1:0] addr, input logic [DW-1:0] val);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = addr; pre_dat = val;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    // Issues one command and checks every cycle's outputs until the block is idle again.
    task automatic do_swap(input logic [AW-1:0] a, input logic [AW-1:0] b, input bit keep,
                           input logic [AW-1:0] na, input logic [AW-1:0] nb,
                           input int abort_at, output int lat);
        logic [DW-1:0] va, vb;
        logic [25:0]   e;
        bit            acc;
        int            end_k;
        lat = -1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr_a = a; cmd_addr_b = b;
        acc = 1'b0;
        for (int w = 0; w < 20 && !acc; w++) begin
            if (cmd_ready) acc = 1'b1;
            else @(negedge clk);
        end
        if (!acc) begin
            check("accept_timeout", 32'd0, 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        va = mem[a];
        vb = mem[b];
        end_k = (a == b) ? 2 : 6;
        for (int k = 1; k <= end_k; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                cmd_valid = keep; cmd_addr_a = na; cmd_addr_b = nb;
            end
            if (a == b) begin
                e = (k == 1) ? expv('0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0)
                             : expv('0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            end else begin
                case (k)
                    1:       e = expv(a,  1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
                    2:       e = expv(b,  1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
                    3:       e = expv('0, 1'b1, a,  vb, 1'b0, 1'b1, 1'b0);
                    4:       e = expv('0, 1'b1, b,  va, 1'b0, 1'b1, 1'b0);
                    5:       e = expv('0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
                    default: e = expv('0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
                endcase
            end
            if (done && lat < 0) lat = k;
            check($sformatf("cycle%0d a=%0d b=%0d", k, a, b), 32'(obs()), 32'(e));
            if (k == abort_at) begin
                reset = 1'b1;
                #1;
                check("abort_outputs", 32'({busy, mem_we, done, cmd_ready, mem_address_w, mem_data_w}), 32'd0);
                @(negedge clk);
                reset = 1'b0;
                return;
            end
        end
        exp_cnt = (exp_cnt + 1) % (1 << CW);
        check("swap_count", 32'(swap_count), 32'(exp_cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[5];
        int   lat;

        vecs[0] = '{a: 7'd3,   b: 7'd9,   va: 8'hAA, vb: 8'h55, exp_lat: 5, exp_fa: 8'h55, exp_fb: 8'hAA};
        vecs[1] = '{a: 7'd4,   b: 7'd4,   va: 8'h12, vb: 8'h12, exp_lat: 1, exp_fa: 8'h12, exp_fb: 8'h12};
        vecs[2] = '{a: 7'd0,   b: 7'd127, va: 8'h3C, vb: 8'hC3, exp_lat: 5, exp_fa: 8'hC3, exp_fb: 8'h3C};
        vecs[3] = '{a: 7'd127, b: 7'd0,   va: 8'h5A, vb: 8'hA5, exp_lat: 5, exp_fa: 8'hA5, exp_fb: 8'h5A};
        vecs[4] = '{a: 7'd10,  b: 7'd11,  va: 8'hFF, vb: 8'h00, exp_lat: 5, exp_fa: 8'h00, exp_fb: 8'hFF};

        reset = 1'b1; cmd_valid = 1'b0; cmd_addr_a = '0; cmd_addr_b = '0;
        pre_we = 1'b0; pre_addr = '0; pre_dat = '0;
        #2;
        check("reset_outputs", 32'(obs()), 32'd0);
        check("reset_count", 32'(swap_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("ready_after_reset", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 5; i++) begin
            preload(vecs[i].a, vecs[i].va);
            if (vecs[i].a != vecs[i].b) preload(vecs[i].b, vecs[i].vb);
            do_swap(vecs[i].a, vecs[i].b, 1'b0, '0, '0, 0, lat);
            check($sformatf("latency vec%0d", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("mem_a vec%0d", i), 32'(mem[vecs[i].a]), 32'(vecs[i].exp_fa));
            check($sformatf("mem_b vec%0d", i), 32'(mem[vecs[i].b]), 32'(vecs[i].exp_fb));
        end

        // Held valid across two commands; changed addresses must not disturb the first.
        preload(7'd1, 8'h11);
        preload(7'd2, 8'h22);
        do_swap(7'd1, 7'd2, 1'b1, 7'd2, 7'd1, 0, lat);
        check("b2b_first_latency", 32'(lat), 32'd5);
        do_swap(7'd2, 7'd1, 1'b0, '0, '0, 0, lat);
        check("b2b_mem1", 32'(mem[1]), 32'h11);
        check("b2b_mem2", 32'(mem[2]), 32'h22);

        // Reset during WR_B: WR_A has landed, WR_B must not.
        preload(7'd5, 8'h01);
        preload(7'd6, 8'h02);
        do_swap(7'd5, 7'd6, 1'b0, '0, '0, 4, lat);
        exp_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("abort_no_done", 32'({done, busy, mem_we}), 32'd0);
        end
        check("abort_mem5", 32'(mem[5]), 32'h02);
        check("abort_mem6", 32'(mem[6]), 32'h02);
        check("abort_count", 32'(swap_count), 32'd0);

        preload(7'd7, 8'h77);
        for (int i = 0; i < (1 << CW); i++) do_swap(7'd7, 7'd7, 1'b0, '0, '0, 0, lat);
        check("count_wrap", 32'(swap_count), 32'd0);
        check("wrap_mem7", 32'(mem[7]), 32'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
